// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the fetch sequencer and its group trimmer.
package fetch_sequencer_pkg;

  localparam int unsigned AddrWDef     = 32;
  localparam int unsigned InstWDef     = 32;
  localparam int unsigned IssueDef     = 4;
  localparam int unsigned InstBytesDef = 4;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StValid,
    StFlush,
    StHalt
  } fetch_state_e;

  // Width of a count that ranges 0..issue inclusive.
  function automatic int unsigned count_width(int unsigned issue);
    return $clog2(issue + 1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_group_trim.sv
// Combinational trimmer: counts leading nonzero words of a fetch group and zeroes
// every word from the first all-zero word onwards.
module fetch_sequencer_group_trim
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned InstW = InstWDef,
  parameter int unsigned Issue = IssueDef,
  localparam int unsigned CntW = count_width(Issue)
) (
  input  logic [Issue*InstW-1:0] data_i,
  output logic [Issue*InstW-1:0] words_o,
  output logic [CntW-1:0]        count_o
);

  logic alive;

  // Walk words in address order; the first zero word ends the group.
  always_comb begin
    alive   = 1'b1;
    count_o = '0;
    words_o = '0;
    for (int i = 0; i < int'(Issue); i++) begin
      if (alive && (data_i[i*InstW +: InstW] != '0)) begin
        words_o[i*InstW +: InstW] = data_i[i*InstW +: InstW];
        count_o                   = count_o + CntW'(1);
      end else begin
        alive = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: holds the fetch PC, requests one group per fetch from the
// instruction cache, trims it and hands it to decode. Redirects override all.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned    AddrW     = AddrWDef,
  parameter int unsigned    InstW     = InstWDef,
  parameter int unsigned    Issue     = IssueDef,
  parameter int unsigned    InstBytes = InstBytesDef,
  parameter logic [AddrW-1:0] ResetPc = '0,
  localparam int unsigned   CntW      = count_width(Issue)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic                   ic_req_o,
  output logic [AddrW-1:0]       ic_addr_o,
  input  logic                   ic_ack_i,
  input  logic [Issue*InstW-1:0] ic_data_i,
  output logic                   dec_valid_o,
  input  logic                   dec_ready_i,
  output logic [AddrW-1:0]       dec_pc_o,
  output logic [Issue*InstW-1:0] dec_insts_o,
  output logic [CntW-1:0]        dec_count_o,
  input  logic                   redirect_valid_i,
  input  logic [AddrW-1:0]       redirect_pc_i,
  output logic                   halted_o
);

  fetch_state_e           state_q;
  logic [AddrW-1:0]       pc_q;
  logic                   ic_req_q;
  logic [AddrW-1:0]       ic_addr_q;
  logic                   dec_valid_q;
  logic [AddrW-1:0]       dec_pc_q;
  logic [Issue*InstW-1:0] dec_insts_q;
  logic [CntW-1:0]        dec_count_q;
  logic                   halted_q;

  logic [Issue*InstW-1:0] trim_words;
  logic [CntW-1:0]        trim_count;
  logic [AddrW-1:0]       pc_next;

  fetch_sequencer_group_trim #(
    .InstW (InstW),
    .Issue (Issue)
  ) u_group_trim (
    .data_i  (ic_data_i),
    .words_o (trim_words),
    .count_o (trim_count)
  );

  // Sequential PC after the accepted group; wraps modulo 2^AddrW.
  assign pc_next = pc_q + AddrW'(dec_count_q) * AddrW'(InstBytes);

  // Single state machine; every output is a register updated here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pc_q        <= ResetPc;
      ic_req_q    <= 1'b0;
      ic_addr_q   <= ResetPc;
      dec_valid_q <= 1'b0;
      dec_pc_q    <= '0;
      dec_insts_q <= '0;
      dec_count_q <= '0;
      halted_q    <= 1'b0;
    end else if (redirect_valid_i) begin
      pc_q        <= redirect_pc_i;
      dec_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      // An unacknowledged request must finish before the address may change.
      if ((state_q == StFetch || state_q == StFlush) && !ic_ack_i) begin
        state_q <= StFlush;
      end else begin
        state_q   <= StFetch;
        ic_req_q  <= 1'b1;
        ic_addr_q <= redirect_pc_i;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q   <= StFetch;
          ic_req_q  <= 1'b1;
          ic_addr_q <= pc_q;
        end
        StFetch: begin
          if (ic_ack_i) begin
            ic_req_q <= 1'b0;
            if (trim_count != '0) begin
              state_q     <= StValid;
              dec_valid_q <= 1'b1;
              dec_pc_q    <= pc_q;
              dec_insts_q <= trim_words;
              dec_count_q <= trim_count;
            end else begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end
          end
        end
        StValid: begin
          if (dec_ready_i) begin
            state_q     <= StFetch;
            dec_valid_q <= 1'b0;
            pc_q        <= pc_next;
            ic_req_q    <= 1'b1;
            ic_addr_q   <= pc_next;
          end
        end
        StFlush: begin
          // Abandoned data is dropped; reissue at the latched redirect target.
          if (ic_ack_i) begin
            state_q   <= StFetch;
            ic_req_q  <= 1'b1;
            ic_addr_q <= pc_q;
          end
        end
        StHalt: begin
          ic_req_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ic_req_o    = ic_req_q;
  assign ic_addr_o   = ic_addr_q;
  assign dec_valid_o = dec_valid_q;
  assign dec_pc_o    = dec_pc_q;
  assign dec_insts_o = dec_insts_q;
  assign dec_count_o = dec_count_q;
  assign halted_o    = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

  logic         clk_i;
  logic         rst_ni;
  logic         ic_req_o;
  logic [31:0]  ic_addr_o;
  logic         ic_ack_i;
  logic [127:0] ic_data_i;
  logic         dec_valid_o;
  logic         dec_ready_i;
  logic [31:0]  dec_pc_o;
  logic [127:0] dec_insts_o;
  logic [2:0]   dec_count_o;
  logic         redirect_valid_i;
  logic [31:0]  redirect_pc_i;
  logic         halted_o;

  int unsigned n_checks;
  int unsigned n_errors;

  fetch_sequencer u_dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .ic_req_o         (ic_req_o),
    .ic_addr_o        (ic_addr_o),
    .ic_ack_i         (ic_ack_i),
    .ic_data_i        (ic_data_i),
    .dec_valid_o      (dec_valid_o),
    .dec_ready_i      (dec_ready_i),
    .dec_pc_o         (dec_pc_o),
    .dec_insts_o      (dec_insts_o),
    .dec_count_o      (dec_count_o),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .halted_o         (halted_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  localparam logic [127:0] Full = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  localparam logic [127:0] Gap  = {32'hDDDD_DDDD, 32'h0, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
  localparam logic [127:0] GapT = {32'h0, 32'h0, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
  localparam logic [127:0] Junk = {32'h5, 32'h6, 32'h7, 32'h8};

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    rst_ni           = 1'b0;
    ic_ack_i         = 1'b0;
    ic_data_i        = '0;
    dec_ready_i      = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;

    step();
    step();
    check("rst_ic_req", ic_req_o, 0);
    check("rst_ic_addr", ic_addr_o, 0);
    check("rst_dec_valid", dec_valid_o, 0);
    check("rst_dec_count", dec_count_o, 0);
    check("rst_halted", halted_o, 0);

    // 1: full group at 0x0, decode ready
    rst_ni = 1'b1;
    step();
    check("t1_req", ic_req_o, 1);
    check("t1_addr", ic_addr_o, 32'h0);
    ic_ack_i    = 1'b1;
    ic_data_i   = Full;
    dec_ready_i = 1'b1;
    step();
    ic_ack_i = 1'b0;
    check("t1_valid", dec_valid_o, 1);
    check("t1_pc", dec_pc_o, 32'h0);
    check("t1_count", dec_count_o, 4);
    check("t1_insts", dec_insts_o, Full);
    check("t1_req_low", ic_req_o, 0);
    step();
    check("t1_next_req", ic_req_o, 1);
    check("t1_next_addr", ic_addr_o, 32'h10);
    check("t1_valid_drop", dec_valid_o, 0);

    // 2+3: gapped group, decode stalls five cycles
    ic_ack_i    = 1'b1;
    ic_data_i   = Gap;
    dec_ready_i = 1'b0;
    step();
    ic_ack_i = 1'b0;
    check("t2_count", dec_count_o, 2);
    check("t2_insts", dec_insts_o, GapT);
    check("t2_pc", dec_pc_o, 32'h10);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_valid", dec_valid_o, 1);
      check("t3_hold_insts", dec_insts_o, GapT);
      check("t3_no_req", ic_req_o, 0);
    end
    dec_ready_i = 1'b1;
    step();
    check("t3_req_after", ic_req_o, 1);
    check("t2_addr_after", ic_addr_o, 32'h18);
    check("t3_valid_drop", dec_valid_o, 0);

    // 4: redirect while request pending, ack three cycles later
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h100;
    step();
    redirect_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("t4_flush_req", ic_req_o, 1);
      check("t4_flush_addr", ic_addr_o, 32'h18);
      step();
    end
    ic_ack_i  = 1'b1;
    ic_data_i = Junk;
    step();
    ic_ack_i = 1'b0;
    check("t4_drop_valid", dec_valid_o, 0);
    check("t4_new_req", ic_req_o, 1);
    check("t4_new_addr", ic_addr_o, 32'h100);

    // 5: all-zero group halts, redirect resumes
    ic_ack_i  = 1'b1;
    ic_data_i = '0;
    step();
    ic_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_halted", halted_o, 1);
      check("t5_no_req", ic_req_o, 0);
      check("t5_no_valid", dec_valid_o, 0);
      step();
    end
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h40;
    step();
    redirect_valid_i = 1'b0;
    check("t5_unhalt", halted_o, 0);
    check("t5_req", ic_req_o, 1);
    check("t5_addr", ic_addr_o, 32'h40);

    // Redirect in VALID beats a simultaneous accept
    ic_ack_i  = 1'b1;
    ic_data_i = Full;
    step();
    ic_ack_i = 1'b0;
    check("rv_valid", dec_valid_o, 1);
    check("rv_pc", dec_pc_o, 32'h40);
    dec_ready_i      = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h200;
    step();
    redirect_valid_i = 1'b0;
    check("rv_drop", dec_valid_o, 0);
    check("rv_addr", ic_addr_o, 32'h200);

    // 6: reset asserted mid-VALID with decode ready
    ic_ack_i  = 1'b1;
    ic_data_i = Gap;
    step();
    ic_ack_i = 1'b0;
    check("t6_valid", dec_valid_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_valid_clr", dec_valid_o, 0);
    check("t6_addr_rst", ic_addr_o, 32'h0);
    check("t6_req_clr", ic_req_o, 0);
    check("t6_count_clr", dec_count_o, 0);
    step();
    rst_ni = 1'b1;
    step();
    check("t6_restart_req", ic_req_o, 1);
    check("t6_restart_addr", ic_addr_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
